// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit.
//   - Size encodings for req_size (byte, half, word).
//   - FSM state type for the access sequencer.
//   - is_misaligned(): alignment/legality check for a size and low address bits.
package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } state_e;

    // Size 3 is not a legal encoding and is reported the same way as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane steering for sub-word accesses (purely combinational).
// Ports:
//   word       - 32-bit word read from memory
//   addr       - byte offset within the word
//   size       - access size (SZ_B / SZ_H / SZ_W)
//   sign_ext   - sign-extend sub-word loads
//   wdata      - right-aligned store data
//   load_data  - extracted and extended load result
//   store_word - read word with the store lane replaced (word stores pass wdata through)
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_B:    load_data = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            SZ_H:    load_data = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: load_data = word;
        endcase

        store_word = word;
        case (size)
            SZ_B: store_word[{addr, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (addr[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator driving the Data_Memory port for the pipeline's memory stage.
// One request at a time; sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake
//   req_we, req_size, req_signed     - store flag, access size, sign-extend flag
//   req_addr, req_wdata              - byte address, right-aligned store data
//   rsp_valid/rsp_ready              - response handshake
//   rsp_rdata, rsp_err               - load result (0 for stores/errors), misalign/illegal flag
//   dm_wr, dm_rd                     - one-cycle memory write/read strobes
//   alu_out, crt                     - memory word index and write data (0 without a strobe)
//   data_rd                          - memory read data, valid RD_LATENCY cycles after dm_rd
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              dm_wr,
    output logic              dm_rd,
    output logic [31:0]       alu_out,
    output logic [31:0]       crt,
    input  logic [31:0]       data_rd
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [31:0] word_idx;

    assign word_idx = 32'(addr_q[ADDR_W-1:2]);

    lane_align u_lane_align (
        .word       (data_rd),
        .addr       (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (req_we && req_size == SZ_W) ? WR : RD;
                    end
                end
            end
            RD: begin
                cnt_d   = CNT_INIT;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (we_q) begin
                        // Merged word replaces wdata so WR can drive crt from one register.
                        wdata_d = store_word;
                        state_d = WR;
                    end else begin
                        rdata_d = load_data;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so a reset drops the strobes without a clock.
    always_comb begin
        req_ready = (state_q == IDLE);
        dm_rd     = (state_q == RD);
        dm_wr     = (state_q == WR);
        alu_out   = (dm_rd || dm_wr) ? word_idx : 32'd0;
        crt       = dm_wr ? wdata_q : 32'd0;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? rdata_q : 32'd0;
        rsp_err   = rsp_valid && err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: two units (RD_LATENCY 1 and 3), each with its own memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    int          sel;

    logic [1:0]  req_v;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [1:0]  dm_wr;
    logic [1:0]  dm_rd;
    logic [31:0] rsp_rdata [2];
    logic [31:0] alu_out [2];
    logic [31:0] crt [2];
    logic [31:0] data_rd [2];

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [16];
        logic [3:0]  rd_idx;
        logic [1:0]  left;
        logic        pend;

        assign req_v[g] = req_valid && (sel == g);

        mem_access_unit #(
            .RD_LATENCY (LAT),
            .ADDR_W     (32)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_v[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we),
            .req_size   (req_size),
            .req_signed (req_signed),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .dm_wr      (dm_wr[g]),
            .dm_rd      (dm_rd[g]),
            .alu_out    (alu_out[g]),
            .crt        (crt[g]),
            .data_rd    (data_rd[g])
        );

        // Read data is only valid in the single cycle LAT cycles after the dm_rd cycle.
        always @(posedge clk) begin
            if (dm_wr[g]) mem[alu_out[g][3:0]] <= crt[g];
            if (!rst_n) begin
                pend <= 1'b0;
                left <= 2'd0;
            end else if (dm_rd[g]) begin
                rd_idx <= alu_out[g][3:0];
                left   <= 2'(LAT - 1);
                pend   <= 1'b1;
            end else if (pend) begin
                if (left == 2'd0) pend <= 1'b0;
                else left <= left - 2'd1;
            end
        end

        assign data_rd[g] = (pend && left == 2'd0) ? mem[rd_idx] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s (unit %0d): got %h, expected %h", tag, sel, got, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_rd, input int exp_wr, input logic [31:0] exp_alu,
                        input logic [31:0] exp_crt, input int exp_lat, input int hold);
        int          n_rd = 0;
        int          n_wr = 0;
        int          lat = 0;
        logic        both = 1'b0;
        logic        bus_bad = 1'b0;
        logic [31:0] alu_rd = '0;
        logic [31:0] alu_wr = '0;
        logic [31:0] got_crt = '0;
        logic [31:0] hold_rdata;
        logic        hold_err;

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[sel]), 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (dm_rd[sel]) begin n_rd++; alu_rd = alu_out[sel]; end
            if (dm_wr[sel]) begin n_wr++; alu_wr = alu_out[sel]; got_crt = crt[sel]; end
            if (dm_rd[sel] && dm_wr[sel]) both = 1'b1;
            if (!dm_rd[sel] && !dm_wr[sel] && (alu_out[sel] != 0 || crt[sel] != 0)) bus_bad = 1'b1;
        end while (!rsp_valid[sel] && lat < 20);

        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_valid", 32'(rsp_valid[sel]), 32'd1);
        check("rsp_err", 32'(rsp_err[sel]), 32'(exp_err));
        check("rsp_rdata", rsp_rdata[sel], exp_rdata);
        check("n_dm_rd", 32'(n_rd), 32'(exp_rd));
        check("n_dm_wr", 32'(n_wr), 32'(exp_wr));
        check("rd_wr_overlap", 32'(both), 32'd0);
        check("bus_idle_zero", 32'(bus_bad), 32'd0);
        if (exp_rd > 0) check("alu_out_rd", alu_rd, exp_alu);
        if (exp_wr > 0) begin
            check("alu_out_wr", alu_wr, exp_alu);
            check("crt", got_crt, exp_crt);
        end

        if (hold > 0) begin
            hold_rdata = rsp_rdata[sel];
            hold_err   = rsp_err[sel];
            rsp_ready  = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 32'(rsp_valid[sel]), 32'd1);
                check("hold_rdata", rsp_rdata[sel], exp_rdata);
                check("hold_rdata_stable", rsp_rdata[sel], hold_rdata);
                check("hold_err", 32'(rsp_err[sel]), 32'(hold_err));
                check("hold_req_ready", 32'(req_ready[sel]), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("rsp_done", 32'(rsp_valid[sel]), 32'd0);
        check("req_ready_back", 32'(req_ready[sel]), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_dm_rd"}, 32'(dm_rd[sel]), 32'd0);
        check({tag, "_dm_wr"}, 32'(dm_wr[sel]), 32'd0);
        check({tag, "_alu_out"}, alu_out[sel], 32'd0);
        check({tag, "_crt"}, crt[sel], 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[sel]), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata[sel], 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err[sel]), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready[sel]), 32'd1);
    endtask

    // Start a request, reset in cycle `at` after acceptance, then confirm no response appears.
    task automatic reset_midway(input logic we, input logic [31:0] addr, input int at,
                                input string tag);
        logic seen = 1'b0;
        @(negedge clk);
        req_we = we; req_size = SZ_W; req_signed = 1'b0; req_addr = addr;
        req_wdata = 32'h5555_AAAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (at) @(negedge clk);
        check({tag, "_strobe_before"}, 32'(we ? dm_wr[sel] : dm_rd[sel]), 32'(at == 1));
        rst_n = 1'b0;
        #1;
        reset_checks(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[sel] || dm_rd[sel] || dm_wr[sel]) seen = 1'b1;
        end
        check({tag, "_no_activity"}, 32'(seen), 32'd0);
        check({tag, "_req_ready_after"}, 32'(req_ready[sel]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_l;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            reset_checks("por");
        end
        rst_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s;
            lat_l = (s == 0) ? 1 : 3;
            // we, size, sgn, addr, wdata, exp_rdata, exp_err, rd, wr, alu, crt, lat, hold
            xfer(1, SZ_W, 0, 32'h8, 32'h0000_000D, 32'h0, 0, 0, 1, 32'd2, 32'hD, 2, 0);
            xfer(0, SZ_W, 1, 32'h8, 32'h0, 32'h0000_000D, 0, 1, 0, 32'd2, 32'h0, lat_l + 2, 0);
            xfer(1, SZ_W, 0, 32'hC, 32'h1122_3344, 32'h0, 0, 0, 1, 32'd3, 32'h1122_3344, 2, 0);
            xfer(1, SZ_B, 0, 32'hD, 32'h1234_56AB, 32'h0, 0, 1, 1, 32'd3, 32'h1122_AB44,
                 lat_l + 3, 0);
            xfer(0, SZ_W, 0, 32'hC, 32'h0, 32'h1122_AB44, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            xfer(1, SZ_W, 0, 32'hC, 32'h8001_0000, 32'h0, 0, 0, 1, 32'd3, 32'h8001_0000, 2, 0);
            xfer(0, SZ_H, 1, 32'hE, 32'h0, 32'hFFFF_8001, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            xfer(0, SZ_H, 0, 32'hE, 32'h0, 32'h0000_8001, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            xfer(0, SZ_B, 1, 32'hF, 32'h0, 32'hFFFF_FF80, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            xfer(1, SZ_H, 0, 32'hC, 32'h1234_BEEF, 32'h0, 0, 1, 1, 32'd3, 32'h8001_BEEF,
                 lat_l + 3, 0);
            xfer(0, SZ_B, 0, 32'hD, 32'h0, 32'h0000_00BE, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            xfer(0, SZ_B, 1, 32'hC, 32'h0, 32'hFFFF_FFEF, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 0);
            // Misaligned and illegal size: no strobes, immediate error response.
            xfer(0, SZ_W, 0, 32'h6, 32'h0, 32'h0, 1, 0, 0, 32'd0, 32'h0, 1, 0);
            xfer(0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'd0, 32'h0, 1, 0);
            xfer(1, SZ_H, 0, 32'h1, 32'hFFFF, 32'h0, 1, 0, 0, 32'd0, 32'h0, 1, 0);
            // Backpressure on a load and on an error response.
            xfer(0, SZ_H, 1, 32'hC, 32'h0, 32'hFFFF_BEEF, 0, 1, 0, 32'd3, 32'h0, lat_l + 2, 3);
            xfer(0, 2'd3, 0, 32'h4, 32'h0, 32'h0, 1, 0, 0, 32'd0, 32'h0, 1, 3);
        end

        sel = 1;
        reset_midway(1'b0, 32'h8, 2, "rst_rd_wait");
        reset_midway(1'b1, 32'h8, 1, "rst_wr");
        // Aborted store must not have landed; unit recovers for normal traffic.
        xfer(0, SZ_W, 0, 32'h8, 32'h0, 32'h0000_000D, 0, 1, 0, 32'd2, 32'h0, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
